// File: rtl/babbage_pkg.sv
// Shared types and helpers for the Babbage difference engine.
package babbage_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultNW    = 7;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StOp,
    StDone
  } state_e;

  // Treat bit (w-1) of v as the sign bit and extend it across the full word.
  function automatic logic [DefaultDataW-1:0] sext(input logic [DefaultDataW-1:0] v,
                                                   input int unsigned w);
    logic signed [DefaultDataW-1:0] t;
    t = signed'(v << (DefaultDataW - w));
    return t >>> (DefaultDataW - w);
  endfunction

endpackage

// File: rtl/babbage_diff_init.sv
// Combinational forward differences of the quintic at n=0, built from shifts and adds.
module babbage_diff_init
  import babbage_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned A_W    = 2,
  parameter int unsigned B_W    = 3,
  parameter int unsigned C_W    = 4,
  parameter int unsigned D_W    = 4,
  parameter int unsigned F_W    = 6,
  parameter int unsigned G_W    = 10
) (
  input  logic signed [A_W-1:0]    a_i,
  input  logic signed [B_W-1:0]    b_i,
  input  logic signed [C_W-1:0]    c_i,
  input  logic signed [D_W-1:0]    d_i,
  input  logic signed [F_W-1:0]    f_i,
  input  logic signed [G_W-1:0]    g_i,
  output logic        [DATA_W-1:0] u0_o,
  output logic        [DATA_W-1:0] d1_o,
  output logic        [DATA_W-1:0] d2_o,
  output logic        [DATA_W-1:0] d3_o,
  output logic        [DATA_W-1:0] d4_o,
  output logic        [DATA_W-1:0] d5_o
);

  logic [DATA_W-1:0] ea, eb, ec, ed, ef, eg;

  assign ea = DATA_W'(signed'(sext(DefaultDataW'($unsigned(a_i)), A_W)));
  assign eb = DATA_W'(signed'(sext(DefaultDataW'($unsigned(b_i)), B_W)));
  assign ec = DATA_W'(signed'(sext(DefaultDataW'($unsigned(c_i)), C_W)));
  assign ed = DATA_W'(signed'(sext(DefaultDataW'($unsigned(d_i)), D_W)));
  assign ef = DATA_W'(signed'(sext(DefaultDataW'($unsigned(f_i)), F_W)));
  assign eg = DATA_W'(signed'(sext(DefaultDataW'($unsigned(g_i)), G_W)));

  assign u0_o = eg;
  assign d1_o = ea + eb + ec + ed + ef;
  // 30a + 14b + 6c + 2d
  assign d2_o = ((ea << 5) - (ea << 1)) + ((eb << 4) - (eb << 1))
              + ((ec << 2) + (ec << 1)) + (ed << 1);
  // 150a + 36b + 6c
  assign d3_o = ((ea << 7) + (ea << 4) + (ea << 2) + (ea << 1))
              + ((eb << 5) + (eb << 2)) + ((ec << 2) + (ec << 1));
  // 240a + 24b
  assign d4_o = ((ea << 8) - (ea << 4)) + ((eb << 4) + (eb << 3));
  // 120a
  assign d5_o = (ea << 7) - (ea << 3);

endmodule

// File: rtl/babbage_top.sv
// Babbage difference engine: evaluates a quintic at n by repeated addition of forward differences.
module babbage_top
  import babbage_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned N_W    = DefaultNW,
  parameter int unsigned A_W    = 2,
  parameter int unsigned B_W    = 3,
  parameter int unsigned C_W    = 4,
  parameter int unsigned D_W    = 4,
  parameter int unsigned F_W    = 6,
  parameter int unsigned G_W    = 10
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic                     start,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  input  logic signed [C_W-1:0]    c,
  input  logic signed [D_W-1:0]    d,
  input  logic signed [F_W-1:0]    f,
  input  logic signed [G_W-1:0]    g,
  input  logic        [N_W-1:0]    n,
  output logic                     ready,
  output logic signed [DATA_W-1:0] babbage_out,
  output logic                     done_tick
);

  state_e            state_q, state_d;
  logic [N_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0] u_q, u_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d, d5_q, d5_d;
  logic [DATA_W-1:0] init_u, init_d1, init_d2, init_d3, init_d4, init_d5;

  babbage_diff_init #(
    .DATA_W(DATA_W),
    .A_W   (A_W),
    .B_W   (B_W),
    .C_W   (C_W),
    .D_W   (D_W),
    .F_W   (F_W),
    .G_W   (G_W)
  ) u_diff_init (
    .a_i (a),
    .b_i (b),
    .c_i (c),
    .d_i (d),
    .f_i (f),
    .g_i (g),
    .u0_o(init_u),
    .d1_o(init_d1),
    .d2_o(init_d2),
    .d3_o(init_d3),
    .d4_o(init_d4),
    .d5_o(init_d5)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    u_d     = u_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    d4_d    = d4_q;
    d5_d    = d5_q;
    unique case (state_q)
      StIdle: begin
        // Differences are captured with start so the coefficients need not be held.
        if (start) begin
          state_d = StInit;
          k_d     = n;
          u_d     = init_u;
          d1_d    = init_d1;
          d2_d    = init_d2;
          d3_d    = init_d3;
          d4_d    = init_d4;
          d5_d    = init_d5;
        end
      end
      StInit: state_d = StOp;
      StOp: begin
        if (k_q == '0) begin
          state_d = StDone;
        end else begin
          u_d  = u_q + d1_q;
          d1_d = d1_q + d2_q;
          d2_d = d2_q + d3_q;
          d3_d = d3_q + d4_q;
          d4_d = d4_q + d5_q;
          k_d  = k_q - N_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      u_q     <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
      d5_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      u_q     <= u_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
      d5_q    <= d5_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done_tick   = (state_q == StDone);
  assign babbage_out = signed'(u_q);

endmodule

// File: tb/tb_babbage_top.sv
// Self-checking bench for babbage_top: directed table, start-while-busy, async reset, random sweep.
module tb_babbage_top;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic signed [1:0] a;
  logic signed [2:0] b;
  logic signed [3:0] c;
  logic signed [3:0] d;
  logic signed [5:0] f;
  logic signed [9:0] g;
  logic        [6:0] n;
  logic              ready;
  logic signed [31:0] babbage_out;
  logic              done_tick;

  always #5 clk = ~clk;

  babbage_top dut (
    .reset      (reset),
    .clk        (clk),
    .start      (start),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .f          (f),
    .g          (g),
    .n          (n),
    .ready      (ready),
    .babbage_out(babbage_out),
    .done_tick  (done_tick)
  );

  typedef struct {
    int res;
    int lat;
  } exp_t;

  typedef struct {
    int a, b, c, d, f, g, n, res;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Horner evaluation in 32-bit int arithmetic (wraps mod 2^32).
  function automatic int model(input int av, bv, cv, dv, fv, gv, nv);
    return ((((av * nv + bv) * nv + cv) * nv + dv) * nv + fv) * nv + gv;
  endfunction

  task automatic drive(input int av, bv, cv, dv, fv, gv, nv);
    a = 2'(av);
    b = 3'(bv);
    c = 4'(cv);
    d = 4'(dv);
    f = 6'(fv);
    g = 10'(gv);
    n = 7'(nv);
  endtask

  task automatic run(input int av, bv, cv, dv, fv, gv, nv, input int expres, input bit inject);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   seen;
    @(negedge clk);
    check("ready_idle", int'(ready), 1);
    drive(av, bv, cv, dv, fv, gv, nv);
    start = 1'b1;
    e.res = expres;
    e.lat = nv + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) check("ready_busy", int'(ready), 0);
      if (inject && cyc == 3) begin
        drive(-2, 3, -8, 7, -32, 100, 5);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_tick) seen = 1'b1;
    end
    start = 1'b0;
    got = sb.pop_front();
    if (!seen) begin
      ncmp++;
      nerr++;
      $display("FAIL done_timeout: got no done_tick in %0d cycles, expected one after %0d",
               cyc, got.lat);
    end else begin
      check("latency", cyc, got.lat);
      check("result", int'(babbage_out), got.res);
    end
  endtask

  task automatic hold_check(input int expres);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_result", int'(babbage_out), expres);
      check("hold_done_low", int'(done_tick), 0);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, -511, 0, -511};
    tbl[1] = '{1, -1, 2, -3, 5, -7, 10, 91743};
    tbl[2] = '{1, 0, 0, 0, 0, 0, 127, -1321368961};
    tbl[3] = '{0, 0, 0, 0, 0, 5, 1, 5};
    tbl[4] = '{0, 0, 0, 0, 1, 0, 127, 127};
    tbl[5] = '{-2, -4, -8, -8, -32, -512, 1, -566};

    reset = 1'b0;
    start = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_out", int'(babbage_out), 0);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done_tick), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].f, tbl[i].g, tbl[i].n, tbl[i].res, 1'b0);
      hold_check(tbl[i].res);
    end

    // Start pulsed mid-computation must not disturb the running request.
    run(1, -1, 2, -3, 5, -7, 10, 91743, 1'b1);
    hold_check(91743);

    // Asynchronous reset in the middle of OP, sampled well inside a quarter period.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 100, 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("async_reset_out", int'(babbage_out), 0);
    check("async_reset_ready", int'(ready), 1);
    check("async_reset_done", int'(done_tick), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", int'(ready), 1);

    for (int i = 0; i < 200; i++) begin
      int av, bv, cv, dv, fv, gv, nv;
      av = int'($urandom_range(0, 3)) - 2;
      bv = int'($urandom_range(0, 7)) - 4;
      cv = int'($urandom_range(0, 15)) - 8;
      dv = int'($urandom_range(0, 15)) - 8;
      fv = int'($urandom_range(0, 63)) - 32;
      gv = int'($urandom_range(0, 1023)) - 512;
      nv = int'($urandom_range(0, 127));
      run(av, bv, cv, dv, fv, gv, nv, model(av, bv, cv, dv, fv, gv, nv), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
